sipo_frame_ctrl: RTL

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_ctrl_pkg.sv | 26 ++
 rtl/sipo_shift_en.sv | 45 ++++
 rtl/sipo_frame_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared types for the serial-in / parallel-out frame controller: element
// layout (X flag plus Y field), the two-lane element, and the FSM states.
package sipo_ctrl_pkg;

    // Y field width that the element typedefs below are laid out for.
    localparam int SIPO_YW = 5;

    // One lane of an input element.
    typedef struct packed {
        logic               x;
        logic [SIPO_YW-1:0] y;
    } sipo_elem_t;

    // One two-lane input element; lane 0 sits in the low half.
    typedef struct packed {
        sipo_elem_t lane1;
        sipo_elem_t lane0;
    } sipo_pair_t;

    // Frame controller states: collecting elements, or presenting a frame.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_shift_en.sv
// DEPTH-stage, two-lane shift register. Slot 0 always holds the newest
// element; a shift with clear_tail loads slot 0 and zeroes every older slot
// so a fresh frame never shows stale data in its unused slots.
module sipo_shift_en #(
    parameter int DEPTH = 5,
    parameter int YW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic                    clear_tail,
    input  logic [1:0]              in_x,
    input  logic [2*YW-1:0]         in_y,
    output logic [DEPTH*2-1:0]      slot_x,
    output logic [DEPTH*2*YW-1:0]   slot_y
);

    localparam int XW    = DEPTH * 2;
    localparam int YBW   = DEPTH * 2 * YW;
    localparam int TAILX = XW - 2;
    localparam int TAILY = YBW - 2 * YW;

    logic [XW-1:0]  x_r;
    logic [YBW-1:0] y_r;

    // Slot storage: clear on reset, otherwise shift one slot per accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if (shift_en) begin
            if (clear_tail) begin
                x_r <= {{TAILX{1'b0}}, in_x};
                y_r <= {{TAILY{1'b0}}, in_y};
            end else begin
                x_r <= {x_r[TAILX-1:0], in_x};
                y_r <= {y_r[TAILY-1:0], in_y};
            end
        end
    end

    assign slot_x = x_r;
    assign slot_y = y_r;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects two-lane elements into a DEPTH-slot frame and
// presents it with a valid/ready handshake. While a frame is presented the
// input is ready only when the frame is being consumed in the same cycle, so
// a consumer that is always ready sees back-to-back frames with no bubble.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int YW    = 5
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          I_0_X,
    input  logic [YW-1:0]                 I_0_Y,
    input  logic                          I_1_X,
    input  logic [YW-1:0]                 I_1_Y,
    input  logic                          I_VALID,
    output logic                          I_READY,
    input  logic                          FLUSH,
    output logic [DEPTH*2-1:0]            O_X,
    output logic [DEPTH*2*YW-1:0]         O_Y,
    output logic [$clog2(DEPTH+1)-1:0]    O_COUNT,
    output logic                          O_VALID,
    input  logic                          O_READY
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [CW-1:0]  ZERO_C  = CW'(0);

    sipo_state_t    state_r;
    sipo_state_t    state_nxt_s;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic           ready_s;
    logic           accept_s;
    logic           shift_s;
    logic           clear_s;

    // Input readiness: always open while filling, follows the consumer
    // while a frame is presented, and closed during reset.
    always_comb begin
        ready_s = 1'b0;
        if (RESET) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                FILL:    ready_s = 1'b1;
                FULL:    ready_s = O_READY;
                default: ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = I_VALID && ready_s;

    // Next state, next count and shift-register controls.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        shift_s     = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    shift_s     = 1'b1;
                    clear_s     = (count_r == ZERO_C);
                    count_nxt_s = count_r + ONE_C;
                    if ((count_r + ONE_C == DEPTH_C) || FLUSH) begin
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else if (FLUSH && (count_r != ZERO_C)) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            FULL: begin
                if (O_READY) begin
                    state_nxt_s = FILL;
                    if (accept_s) begin
                        // Refill in the drain cycle: the new element opens a
                        // fresh frame, so the older slots are cleared.
                        shift_s     = 1'b1;
                        clear_s     = 1'b1;
                        count_nxt_s = ONE_C;
                    end else begin
                        count_nxt_s = ZERO_C;
                    end
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = FILL;
                count_nxt_s = ZERO_C;
            end
        endcase
    end

    // State and count registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= FILL;
            count_r <= ZERO_C;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    sipo_shift_en #(
        .DEPTH (DEPTH),
        .YW    (YW)
    ) u_shift (
        .clk        (CLK),
        .rst        (RESET),
        .shift_en   (shift_s),
        .clear_tail (clear_s),
        .in_x       ({I_1_X, I_0_X}),
        .in_y       ({I_1_Y, I_0_Y}),
        .slot_x     (O_X),
        .slot_y     (O_Y)
    );

    assign I_READY = ready_s;
    assign O_VALID = (state_r == FULL) && !RESET;
    assign O_COUNT = count_r;

endmodule
